// File: rtl/rnd_pkg.sv
// Shared definitions for the randomness feeder: xorshift32 constants, FSM states
// and the refresh-word count of the downstream full-XOR unmasking stage.
package rnd_pkg;

  localparam logic [31:0] XS_DEFAULT_SEED = 32'h2545F491;
  localparam int          XS_SHIFT_A      = 13;
  localparam int          XS_SHIFT_B      = 17;
  localparam int          XS_SHIFT_C      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } feed_state_e;

  // Refresh words consumed per unmasking operation for n_shares shares.
  function automatic int randnum(input int n_shares);
    int log_k;
    log_k = $clog2(n_shares + 1) - 1;
    if (n_shares == 1) return 0;
    return log_k * (1 << (log_k - 1)) + n_shares - (1 << log_k);
  endfunction

endpackage

// File: rtl/xorshift32_step.sv
// One combinational xorshift32 step (13/17/5); shared by all xorshift generators.
module xorshift32_step
  import rnd_pkg::*;
(
  input  logic [31:0] i_x,
  output logic [31:0] o_z
);

  logic [31:0] t_a;
  logic [31:0] t_b;

  assign t_a = i_x ^ (i_x << XS_SHIFT_A);
  assign t_b = t_a ^ (t_a >> XS_SHIFT_B);
  assign o_z = t_b ^ (t_b << XS_SHIFT_C);

endmodule

// File: rtl/rnd_feeder_n8.sv
// Randomness supply for the 8-share unmasking stage: fills a RANDNUM-word buffer
// from a seeded xorshift32 stream and refills it after every consumer take.
//
// state | meaning
// IDLE  | unseeded, outputs inert, takes ignored
// FILL  | writing one fresh word per enabled cycle
// FULL  | vector complete and unused, o_rvld high
module rnd_feeder_n8
  import rnd_pkg::*;
#(
  parameter  int K_WIDTH  = 32,
  parameter  int N_SHARES = 8,
  localparam int LOG_K    = $clog2(N_SHARES + 1) - 1,
  localparam int RANDNUM  = (N_SHARES == 1) ? 0
                          : LOG_K * (2 ** (LOG_K - 1)) + N_SHARES - 2 ** LOG_K
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       i_seed_vld,
  input  logic [31:0]                i_seed,
  input  logic                       i_take,
  output logic [K_WIDTH*RANDNUM-1:0] o_rnd,
  output logic                       o_rvld,
  output logic                       o_busy
);

  localparam int                 CNT_W    = (RANDNUM > 1) ? $clog2(RANDNUM) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RANDNUM - 1);

  // The shift constants only produce a full-period generator on 32-bit words.
  if (K_WIDTH != 32) begin : g_bad_width
    $error("rnd_feeder_n8: K_WIDTH must be 32");
  end
  if (RANDNUM != randnum(N_SHARES)) begin : g_bad_randnum
    $error("rnd_feeder_n8: RANDNUM disagrees with rnd_pkg::randnum");
  end

  feed_state_e                state_q;
  feed_state_e                state_d;
  logic [31:0]                x_q;
  logic [31:0]                x_next;
  logic [CNT_W-1:0]           cnt_q;
  logic [K_WIDTH*RANDNUM-1:0] rnd_q;
  logic [31:0]                seed_val;
  logic                       last_word;

  xorshift32_step u_step (
    .i_x (x_q),
    .o_z (x_next)
  );

  // A zero seed would lock xorshift at zero forever.
  assign seed_val  = (i_seed == 32'd0) ? XS_DEFAULT_SEED : i_seed;
  assign last_word = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      if (i_seed_vld) begin
        state_d = FILL;
      end else begin
        case (state_q)
          FILL:    if (last_word) state_d = FULL;
          FULL:    if (i_take)    state_d = FILL;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    o_rvld = 1'b0;
    o_busy = 1'b0;
    case (state_q)
      FILL:    o_busy = 1'b1;
      FULL:    o_rvld = 1'b1;
      default: ;
    endcase
  end

  // Seeding restarts the fill from word 0, discarding any partial vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      cnt_q <= '0;
      rnd_q <= '0;
    end else if (ena) begin
      if (i_seed_vld) begin
        x_q   <= seed_val;
        cnt_q <= '0;
      end else if (state_q == FILL) begin
        rnd_q[int'(cnt_q)*K_WIDTH +: K_WIDTH] <= x_next;
        x_q   <= x_next;
        cnt_q <= last_word ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign o_rnd = rnd_q;

endmodule

// File: tb/tb_rnd_feeder_n8.sv
// Self-checking bench for rnd_feeder_n8: seed table, take/refill, enable pause,
// seed-vs-take priority, async reset and a long refill run against a scoreboard.
module tb_rnd_feeder_n8;

  localparam int KW = 32;
  localparam int NW = 12;
  localparam int VW = KW * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          i_seed_vld;
  logic [31:0]   i_seed;
  logic          i_take;
  logic [VW-1:0] o_rnd;
  logic          o_rvld;
  logic          o_busy;

  always #5 clk = ~clk;

  rnd_feeder_n8 dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .i_seed_vld (i_seed_vld),
    .i_seed     (i_seed),
    .i_take     (i_take),
    .o_rnd      (o_rnd),
    .o_rvld     (o_rvld),
    .o_busy     (o_busy)
  );

  typedef struct {
    logic [31:0] seed;
    int          lat;
    bit          known;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] last_exp;
  logic [31:0]   mx;
  vec_t          tbl[4];

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ {x[18:0], 13'b0};
    t = t ^ {17'b0, t[31:17]};
    t = t ^ {t[26:0], 5'b0};
    return t;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_fill();
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++) begin
      mx = xs_next(mx);
      v[j*KW +: KW] = mx;
    end
    sb.push_back(v);
  endtask

  task automatic start_seed(input logic [31:0] s);
    ena        = 1'b1;
    i_seed     = s;
    i_seed_vld = 1'b1;
    mx = (s == 32'd0) ? 32'h2545F491 : s;
    model_fill();
  endtask

  task automatic start_take();
    ena    = 1'b1;
    i_take = 1'b1;
    model_fill();
  endtask

  // Called at the negedge of the cycle whose inputs start a fill.
  task automatic wait_full(input string name, input int exp_lat, input int take_at,
                           input int pause_at, input int pause_len);
    int lat;
    int busy_bad;
    lat      = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      i_seed_vld = 1'b0;
      i_take     = (lat == take_at);
      ena        = !(lat >= pause_at && lat < pause_at + pause_len);
      if (!o_rvld && !o_busy) busy_bad++;
    end while (!o_rvld && lat < 60);
    i_take = 1'b0;
    ena    = 1'b1;
    chk({name, "_lat"}, VW'(lat), VW'(exp_lat));
    chk({name, "_busy_fill"}, VW'(busy_bad), '0);
    chk({name, "_busy_full"}, VW'(o_busy), '0);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_vec: scoreboard empty, got %0h", name, o_rnd);
    end else begin
      last_exp = sb.pop_front();
      chk({name, "_vec"}, o_rnd, last_exp);
    end
  endtask

  initial begin
    int zc;
    tbl[0] = '{seed: 32'h00000001, lat: 13, known: 1'b1, w0: 32'h00042021, w1: 32'h04080601};
    tbl[1] = '{seed: 32'h00000000, lat: 13, known: 1'b0, w0: 32'h0, w1: 32'h0};
    tbl[2] = '{seed: 32'hDEADBEEF, lat: 13, known: 1'b0, w0: 32'h0, w1: 32'h0};
    tbl[3] = '{seed: 32'h80000000, lat: 13, known: 1'b0, w0: 32'h0, w1: 32'h0};

    rst = 1'b1; ena = 1'b1; i_seed_vld = 1'b0; i_take = 1'b0; i_seed = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst_rnd", o_rnd, '0);
    chk("rst_rvld", VW'(o_rvld), '0);
    chk("rst_busy", VW'(o_busy), '0);
    rst = 1'b0;

    i_take = 1'b1;
    @(negedge clk);
    i_take = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_take_rvld", VW'(o_rvld), '0);
    chk("idle_take_busy", VW'(o_busy), '0);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] eff;
      @(negedge clk);
      eff = (tbl[i].seed == 32'd0) ? 32'h2545F491 : tbl[i].seed;
      start_seed(tbl[i].seed);
      wait_full($sformatf("seed%0d", i), tbl[i].lat, 0, 0, 0);
      chk($sformatf("seed%0d_w0", i), VW'(o_rnd[31:0]), VW'(xs_next(eff)));
      if (tbl[i].known) begin
        chk($sformatf("seed%0d_w0_const", i), VW'(o_rnd[31:0]), VW'(tbl[i].w0));
        chk($sformatf("seed%0d_w1_const", i), VW'(o_rnd[63:32]), VW'(tbl[i].w1));
      end
      repeat (3) @(negedge clk);
      chk($sformatf("seed%0d_hold", i), o_rnd, last_exp);
      chk($sformatf("seed%0d_hold_rvld", i), VW'(o_rvld), VW'(1));
    end

    start_take();
    wait_full("take", 13, 0, 0, 0);

    ena = 1'b0;
    i_take = 1'b1;
    repeat (3) @(negedge clk);
    chk("ena_low_take_rvld", VW'(o_rvld), VW'(1));
    chk("ena_low_take_rnd", o_rnd, last_exp);
    ena = 1'b1;
    i_take = 1'b0;
    @(negedge clk);

    start_take();
    wait_full("pause", 18, 0, 4, 5);

    start_take();
    wait_full("take_in_fill", 13, 3, 0, 0);

    i_take = 1'b1;
    start_seed(32'h12345678);
    wait_full("seed_take", 13, 0, 0, 0);

    @(negedge clk);
    start_seed(32'hCAFEF00D);
    @(negedge clk);
    i_seed_vld = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rnd", o_rnd, '0);
    chk("async_rst_rvld", VW'(o_rvld), '0);
    chk("async_rst_busy", VW'(o_busy), '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_rvld", VW'(o_rvld), '0);
    chk("post_rst_busy", VW'(o_busy), '0);
    chk("post_rst_rnd", o_rnd, '0);

    start_seed(32'h00000000);
    wait_full("long_seed", 13, 0, 0, 0);
    zc = 0;
    for (int k = 0; k < 1000; k++) begin
      start_take();
      wait_full($sformatf("long%0d", k), 13, 0, 0, 0);
      for (int j = 0; j < NW; j++)
        if (o_rnd[j*KW +: KW] == 32'd0) zc++;
    end
    chk("long_no_zero_word", VW'(zc), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
